// File: rtl/cdb_banked_arb_pkg.sv
// Shared CDB types and sizing constants used by the arbiter, the ROB and the wakeup logic.
// Latency: n/a (types only).
// Backpressure: n/a.
package cdb_banked_arb_pkg;

    localparam int CDB_PORT_COUNT = 4;
    localparam int CDB_LANE_COUNT = 2;
    localparam int ROB_ID_W       = 6;
    localparam int XLEN           = 32;

    typedef struct packed {
        logic                r_valid;
        logic [ROB_ID_W-1:0] rob_id;
        logic [XLEN-1:0]     w_data;
    } cdb_info_t;

endpackage

// File: rtl/cdb_banked_arb_if.sv
// Producer result handshake: valid/ready with a cdb_info_t payload.
// Latency: n/a (wires only).
// Backpressure: the receiver drives ready; the sender must not make valid depend on it.
interface cdb_banked_arb_if;
    import cdb_banked_arb_pkg::*;

    logic      valid;
    logic      ready;
    cdb_info_t data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/cdb_rr_arbiter.sv
// Per-lane arbiter: round-robin with its own grant pointer when CDB_RR_ARB_EN is defined, else fixed priority.
// Latency: combinational grant; the pointer advances at the clk edge after a grant.
// Backpressure: flush suppresses all grants and returns the pointer to 0.
module cdb_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

`ifdef CDB_RR_ARB_EN
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt_idx;
    logic          gnt_any;

    // Scan from the pointer upward, wrapping modulo N; the first requester wins.
    always_comb begin
        int            idx;
        logic [PW-1:0] idx_b;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        idx_b   = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_b = PW'(idx);
            if (!gnt_any && !flush && req[idx_b]) begin
                gnt[idx_b] = 1'b1;
                gnt_idx    = idx_b;
                gnt_any    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (flush) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    always_comb begin
        logic found;
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && !flush && req[k]) begin
                gnt[k] = 1'b1;
                found  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/cdb_banked_arb.sv
// Banked CDB arbiter: PORT_COUNT result FIFOs onto LANE_COUNT lanes chosen by rob_id low bits (RR under CDB_RR_ARB_EN).
// Latency: 1 cycle from the ready&valid handshake to cdb_data_o; no internal buffering.
// Backpressure: ready is combinational; losers stall, entries without r_valid and all ports during flush drain.
module cdb_banked_arb
    import cdb_banked_arb_pkg::*;
#(
    parameter int PORT_COUNT = CDB_PORT_COUNT,
    parameter int LANE_COUNT = CDB_LANE_COUNT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    cdb_banked_arb_if.slave        fifo_handshake [PORT_COUNT],
    output cdb_info_t              cdb_data_o [LANE_COUNT]
);

    localparam int               LANE_W    = (LANE_COUNT > 1) ? $clog2(LANE_COUNT) : 1;
    localparam logic [LANE_W-1:0] LANE_MASK = LANE_W'(LANE_COUNT - 1);

    logic [PORT_COUNT-1:0] port_vld;
    logic [PORT_COUNT-1:0] port_rv;
    logic [PORT_COUNT-1:0] port_gnt;
    cdb_info_t             port_dat [PORT_COUNT];

    logic [PORT_COUNT-1:0] req [LANE_COUNT];
    logic [PORT_COUNT-1:0] gnt [LANE_COUNT];
    cdb_info_t             sel [LANE_COUNT];

    for (genvar i = 0; i < PORT_COUNT; i++) begin : g_port
        assign port_vld[i]              = fifo_handshake[i].valid;
        assign port_dat[i]              = fifo_handshake[i].data;
        assign port_rv[i]               = port_dat[i].r_valid;
        assign fifo_handshake[i].ready  = port_gnt[i] | ~port_rv[i] | flush;
    end

    // Each port lands in exactly one bank; the mask keeps a single-lane build on lane 0.
    always_comb begin
        for (int l = 0; l < LANE_COUNT; l++) begin
            req[l] = '0;
            for (int i = 0; i < PORT_COUNT; i++) begin
                req[l][i] = port_vld[i] & port_rv[i] &
                            ((port_dat[i].rob_id[LANE_W-1:0] & LANE_MASK) == LANE_W'(l));
            end
        end
    end

    for (genvar l = 0; l < LANE_COUNT; l++) begin : g_lane
        cdb_rr_arbiter #(
            .N (PORT_COUNT)
        ) u_arb (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush),
            .req   (req[l]),
            .gnt   (gnt[l])
        );
    end

    always_comb begin
        port_gnt = '0;
        for (int l = 0; l < LANE_COUNT; l++) begin
            port_gnt = port_gnt | gnt[l];
        end
    end

    // One-hot AND-OR mux; an idle lane yields all-zero, so r_valid doubles as lane valid.
    always_comb begin
        for (int l = 0; l < LANE_COUNT; l++) begin
            sel[l] = '0;
            for (int i = 0; i < PORT_COUNT; i++) begin
                sel[l] = sel[l] | (port_dat[i] & {$bits(cdb_info_t){gnt[l][i]}});
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < LANE_COUNT; l++) begin
                cdb_data_o[l] <= '0;
            end
        end else if (flush) begin
            for (int l = 0; l < LANE_COUNT; l++) begin
                cdb_data_o[l] <= '0;
            end
        end else begin
            for (int l = 0; l < LANE_COUNT; l++) begin
                cdb_data_o[l] <= sel[l];
            end
        end
    end

endmodule
